// File: rtl/cv32e40s_rr_arbiter.sv
// rtl/cv32e40s_rr_arbiter.sv - round-robin arbiter with hold-until-done grants and a hold watchdog
module cv32e40s_rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       done_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       gnt_valid_o,
    output logic                       timeout_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               timeout_q, timeout_d;

    function automatic logic [IDX_W-1:0] first_one(input logic [NUM_REQ-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Requests strictly above the pointer take precedence; otherwise wrap to the lowest.
    function automatic logic [IDX_W-1:0] winner(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   p);
        logic [NUM_REQ-1:0] m;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            m[i] = r[i] && (i > int'(p));
        end
        return (|m) ? first_one(m) : first_one(r);
    endfunction

    logic [IDX_W-1:0]   arb_ptr;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] req_others;
    logic               hold_expired;
    logic               release_ev;

    assign arb_ptr      = (state_q == GRANT) ? gnt_idx_q : last_q;
    assign win_idx      = winner(req_i, arb_ptr);
    assign win_onehot   = NUM_REQ'(1) << win_idx;
    assign req_others   = req_i & ~gnt_q;
    assign hold_expired = (hold_cnt_q == HOLD_LAST);
    assign release_ev   = (state_q == GRANT) && (done_i || hold_expired);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d      = win_onehot;
                    gnt_idx_d  = win_idx;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (release_ev) begin
                    last_d     = gnt_idx_q;
                    timeout_d  = !done_i;
                    hold_cnt_d = '0;
                    // Handing over at the release edge avoids a bubble; the holder is never re-picked
                    // because any other request outranks it in the masked or wrapped search.
                    if (|req_others) begin
                        gnt_d     = win_onehot;
                        gnt_idx_d = win_idx;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (!hold_expired) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            last_q     <= IDX_LAST;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_valid_o = |gnt_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_cv32e40s_rr_arbiter.sv
// tb/tb_cv32e40s_rr_arbiter.sv - randomized and directed checks of the round-robin arbiter against a reference model
module tb_cv32e40s_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt_o;
    logic [1:0]   gnt_idx_o;
    logic         gnt_valid_o;
    logic         timeout_o;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Reference model: grant held as (valid, index), age counts grant cycles so far.
    bit m_valid = 1'b0;
    int m_idx   = 0;
    int m_last  = N - 1;
    int m_age   = 0;
    bit m_to    = 1'b0;

    cv32e40s_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .done_i      (done),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Walk the ring starting just after p; the first requester met wins.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (p + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_last  = N - 1;
            m_age   = 0;
            m_to    = 1'b0;
        end else if (!m_valid) begin
            m_to = 1'b0;
            if (req != 0) begin
                m_idx   = rr_pick(req, m_last);
                m_valid = 1'b1;
                m_age   = 1;
            end
        end else begin
            bit rel;
            logic [N-1:0] others;
            rel  = done || (m_age == MH);
            m_to = rel && !done;
            if (rel) begin
                m_last = m_idx;
                others = req;
                others[m_idx] = 1'b0;
                if (others != 0) m_idx = rr_pick(others, m_idx);
                else m_valid = 1'b0;
                m_age = 1;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            int exp_gnt;
            exp_gnt = m_valid ? (1 << m_idx) : 0;
            chk("model_gnt", int'(gnt_o), exp_gnt);
            chk("model_valid", int'(gnt_valid_o), int'(m_valid));
            chk("model_timeout", int'(timeout_o), int'(m_to));
            if (m_valid) chk("model_idx", int'(gnt_idx_o), m_idx);
            chk("inv_idx_bit", int'(gnt_o[gnt_idx_o]), int'(gnt_valid_o));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int fair_exp [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        tick();
        tick();
        check_en = 1'b1;
        chk("reset_gnt", int'(gnt_o), 0);
        chk("reset_idx", int'(gnt_idx_o), 0);
        chk("reset_valid", int'(gnt_valid_o), 0);
        chk("reset_timeout", int'(timeout_o), 0);
        rst = 1'b0;

        req = 4'b1010;
        tick();
        chk("basic_gnt", int'(gnt_o), 4'b0010);
        chk("basic_idx", int'(gnt_idx_o), 1);
        done = 1'b1;
        tick();
        chk("basic_b2b_gnt", int'(gnt_o), 4'b1000);
        req = '0;
        tick();
        done = 1'b0;

        do_reset();
        req = 4'b1111;
        tick();
        chk("fair_0", int'(gnt_idx_o), fair_exp[0]);
        done = 1'b1;
        for (int k = 1; k < 6; k++) begin
            tick();
            chk($sformatf("fair_%0d", k), int'(gnt_idx_o), fair_exp[k]);
        end
        req = '0;
        tick();
        done = 1'b0;

        do_reset();
        req = 4'b1000;
        tick();
        chk("wrap_first", int'(gnt_idx_o), 3);
        req  = 4'b0101;
        done = 1'b1;
        tick();
        chk("wrap_idx0", int'(gnt_idx_o), 0);
        tick();
        chk("wrap_idx2", int'(gnt_idx_o), 2);
        req = '0;
        tick();
        done = 1'b0;

        req = 4'b0100;
        tick();
        chk("sole_valid_1", int'(gnt_valid_o), 1);
        done = 1'b1;
        tick();
        chk("sole_valid_0", int'(gnt_valid_o), 0);
        done = 1'b0;
        tick();
        chk("sole_valid_2", int'(gnt_valid_o), 1);
        chk("sole_idx", int'(gnt_idx_o), 2);
        req  = '0;
        done = 1'b1;
        tick();
        done = 1'b0;

        do_reset();
        req = 4'b0011;
        tick();
        chk("wd_first", int'(gnt_idx_o), 0);
        for (int c = 2; c <= MH; c++) tick();
        chk("wd_held16_valid", int'(gnt_valid_o), 1);
        chk("wd_held16_timeout", int'(timeout_o), 0);
        tick();
        chk("wd_timeout_pulse", int'(timeout_o), 1);
        chk("wd_next_idx", int'(gnt_idx_o), 1);
        tick();
        chk("wd_pulse_end", int'(timeout_o), 0);
        for (int c = 3; c <= MH; c++) tick();
        done = 1'b1;
        tick();
        chk("wd_done_same_cycle", int'(timeout_o), 0);
        chk("wd_done_next_idx", int'(gnt_idx_o), 0);
        done = 1'b0;

        req = '0;
        tick();
        tick();
        tick();
        chk("drop_valid", int'(gnt_valid_o), 1);
        chk("drop_idx", int'(gnt_idx_o), 0);
        rst = 1'b1;
        tick();
        chk("midrst_gnt", int'(gnt_o), 0);
        chk("midrst_timeout", int'(timeout_o), 0);
        rst = 1'b0;
        req = 4'b0110;
        tick();
        chk("postrst_idx", int'(gnt_idx_o), 1);
        req  = '0;
        done = 1'b1;
        tick();
        done = 1'b0;

        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 1000; i++) begin
                req = N'($urandom_range(0, (1 << N) - 1));
                case (ph)
                    0: done = ($urandom_range(0, 1) == 0);
                    1: done = ($urandom_range(0, 7) == 0);
                    2: done = ($urandom_range(0, 31) == 0);
                    default: done = 1'b0;
                endcase
                rst = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        rst  = 1'b0;
        req  = '0;
        done = 1'b0;
        check_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40s_rr_arbiter.md
Name: cv32e40s_rr_arbiter

Overview:
- Round-robin arbiter sharing a single resource (e.g. a shared bus port or functional unit) between NUM_REQ requesters.
- Winner selection uses two find-first-one searches: one over the requests masked to indices above the last grant, and one fallback over all requests.
- Each grant is held until the resource signals completion.
- A hold watchdog forcibly releases a grant that never completes.

Parameters:
- NUM_REQ, 4, number of requesters; must be ≥2.
- MAX_HOLD, 16, maximum cycles a grant may be held without done_i; must be ≥2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req_i  input  NUM_REQ  request vector; bit n = requester n wants the resource.
- done_i  input  1  resource finished the current granted transaction.
- gnt_o  output  NUM_REQ  one-hot grant, registered.
- gnt_idx_o  output  $clog2(NUM_REQ)  index of the granted requester, registered.
- gnt_valid_o  output  1  a grant is active (OR of gnt_o).
- timeout_o  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, timeout_o=0.
  - last_q=NUM_REQ-1, so requester 0 has highest priority after reset.
  - hold_cnt=0, state IDLE.
- Reset mid-grant drops the grant at the next edge; no timeout_o is generated.
- Winner function (combinational), given request vector R and pointer P:
  - M = R with bits [P:0] cleared.
  - If M≠0, winner = first one of M; otherwise winner = first one of R.
  - "First one" means the lowest set index.
- State IDLE:
  - done_i is ignored.
  - If req_i≠0: at the edge, load gnt_o=onehot(winner(req_i,last_q)), load gnt_idx_o, set gnt_valid_o=1, clear hold_cnt, go GRANT.
  - Latency is one cycle from request to grant.
- State GRANT:
  - The grant is held regardless of req_i; done_i is authoritative.
  - If the granted requester drops req_i while granted, this has no effect.
  - Each cycle without done_i, hold_cnt increments, saturating at MAX_HOLD-1.
- Release event: done_i=1, or hold_cnt==MAX_HOLD-1 with done_i=0 (timeout).
  - On release, last_q<=gnt_idx_o.
  - If req_i with the granted bit excluded ≠0, arbitrate winner(req_i,gnt_idx_o) and grant it at the same edge, staying in GRANT with hold_cnt cleared. There is no bubble cycle.
  - Otherwise go IDLE with gnt_o=0 and gnt_valid_o=0.
  - The just-released requester is lowest priority and is not regranted back-to-back. It wins again only after one IDLE cycle.
- Timeout: timeout_o=1 for exactly the cycle following the forced-release edge.
  - A grant with no done_i releases after exactly MAX_HOLD cycles of gnt_valid_o=1.
  - done_i in the same cycle as the watchdog expiry counts as normal completion: no timeout_o.
- Invariants:
  - gnt_o is zero or one-hot.
  - gnt_o[gnt_idx_o]==gnt_valid_o.
  - A grant is issued only to a requester whose req_i was 1 at the arbitration edge.

Test Plan:
- Reset, then req_i=4'b1010 → next cycle gnt_o=4'b0010, gnt_idx_o=1. After done_i → gnt_o=4'b1000 back-to-back in the same edge.
- Fairness: req_i=4'b1111 held, done_i pulsed each grant → grant order 0,1,2,3,0,1.
- Wrap: last grant idx 3, req_i=4'b0101 → grant idx 0. Then after done_i → idx 2.
- Sole requester: req_i=4'b0100 constant, done_i pulsed → grant, IDLE one cycle, then regrant idx 2. gnt_valid_o pattern 1,0,1.
- Watchdog: MAX_HOLD=16, grant idx 0, done_i never asserted → release after 16 grant cycles, timeout_o=1 for one cycle, next requester granted. Repeat with done_i in cycle 16 → timeout_o stays 0.
- Reset mid-grant and req drop: req withdrawn while granted → grant persists until done_i. Assert rst during GRANT → gnt_o=0 at the next edge; the following grant goes to the lowest requesting index.
